// File: rtl/cdb_arbiter_if.sv
// Shared CDB payload type and the bundle between the functional units and
// the CDB arbiter.
//   fu_done   : FU i holds a valid result (FU -> arbiter)
//   fu_data   : result payload per FU     (FU -> arbiter)
//   cdb_ack   : grant to FU i, same cycle (arbiter -> FU)
//   cdb_valid : lane k broadcast valid    (arbiter -> RS/ROB/RF)
//   cdb_data  : lane k payload            (arbiter -> RS/ROB/RF)
// Modport master is the arbiter side; slave is the FU/consumer side.

package cdb_arbiter_pkg;
    typedef struct packed {
        logic [5:0]  rob_tag;
        logic [31:0] value;
        logic        exc;
    } fu_cdb_data_t;
endpackage

interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FUS = 4,
    parameter int unsigned NUM_CDB = 2
);
    logic         [NUM_FUS-1:0] fu_done;
    fu_cdb_data_t [NUM_FUS-1:0] fu_data;
    logic         [NUM_FUS-1:0] cdb_ack;
    logic         [NUM_CDB-1:0] cdb_valid;
    fu_cdb_data_t [NUM_CDB-1:0] cdb_data;

    modport master (
        input  fu_done, fu_data,
        output cdb_ack, cdb_valid, cdb_data
    );

    modport slave (
        output fu_done, fu_data,
        input  cdb_ack, cdb_valid, cdb_data
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. Grants up to NUM_CDB completing FUs per cycle in
// round-robin order starting at ptr, acks them combinationally, and
// broadcasts the granted payloads on the following clock edge.
// Ports:
//   clk               : clock
//   rst               : asynchronous active-high reset
//   branch_mispredict : flush; suppresses all grants this cycle
//   bus               : cdb_arbiter_if.master (fu_done/fu_data in,
//                       cdb_ack/cdb_valid/cdb_data out)

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FUS = 4,
    parameter int unsigned NUM_CDB = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          branch_mispredict,
    cdb_arbiter_if.master bus
);
    localparam int unsigned FU_W   = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;
    localparam int unsigned LANE_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

    logic [FU_W-1:0]                ptr;
    logic [FU_W-1:0]                ptr_nxt;
    logic [NUM_FUS-1:0]             ack;
    logic [NUM_CDB-1:0]             lane_vld;
    logic [NUM_CDB-1:0][FU_W-1:0]   lane_sel;
    logic [NUM_CDB-1:0]             valid_q;
    fu_cdb_data_t                   data_q [NUM_CDB];

    // Round-robin scan from ptr; the j-th requester found is steered to lane j.
    always_comb begin
        logic [FU_W-1:0]   idx;
        logic [LANE_W-1:0] lane;
        int unsigned       n_grant;
        int unsigned       pos;

        ack      = '0;
        lane_vld = '0;
        lane_sel = '0;
        ptr_nxt  = ptr;
        idx      = '0;
        lane     = '0;
        n_grant  = 0;
        pos      = 0;

        if (!rst && !branch_mispredict) begin
            for (int unsigned j = 0; j < NUM_FUS; j++) begin
                pos = 32'(ptr) + j;
                if (pos >= NUM_FUS) begin
                    pos = pos - NUM_FUS;
                end
                idx = FU_W'(pos);
                if (bus.fu_done[idx] && (n_grant < NUM_CDB)) begin
                    ack[idx]       = 1'b1;
                    lane_vld[lane] = 1'b1;
                    lane_sel[lane] = idx;
                    ptr_nxt        = (pos == NUM_FUS - 1) ? '0 : FU_W'(pos + 1);
                    lane           = lane + 1'b1;
                    n_grant        = n_grant + 1;
                end
            end
        end
    end

    assign bus.cdb_ack   = ack;
    assign bus.cdb_valid = valid_q;

    // With no grants (idle or flush) ptr_nxt == ptr, so the pointer holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            valid_q <= '0;
        end else begin
            ptr     <= ptr_nxt;
            valid_q <= lane_vld;
        end
    end

    // Payload registers only load on a grant; idle lanes keep stale data.
    for (genvar k = 0; k < NUM_CDB; k++) begin : g_lane
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q[k] <= '0;
            end else if (lane_vld[k]) begin
                data_q[k] <= bus.fu_data[lane_sel[k]];
            end
        end
        assign bus.cdb_data[k] = data_q[k];
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Consumes completion requests from all execution functional units (ALU/CMP, mul/div, load/store) and grants up to NUM_CDB of them per cycle onto the common data bus.
- Uses a round-robin priority pointer for fairness.
- Returns a per-FU ack that releases the FU's result hold.
- Broadcasts granted results one cycle later, registered, to the reservation stations, ROB and register file.

Parameters:
- NUM_FUS, 4, number of requesting functional units; ALU/CMP units occupy the low indices.
- NUM_CDB, 2, number of CDB broadcast lanes; must satisfy 1 <= NUM_CDB <= NUM_FUS.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- branch_mispredict  input  1  pipeline flush
- fu_done  input  NUM_FUS  FU i holds a valid result
- fu_data  input  fu_cdb_data_t[NUM_FUS]  result payload per FU
- cdb_ack  output  NUM_FUS  grant to FU i, combinational, same cycle
- cdb_valid  output  NUM_CDB  lane k carries a valid broadcast (registered)
- cdb_data  output  fu_cdb_data_t[NUM_CDB]  lane k payload (registered)

Behaviour:
- Reset (async, rst=1): cdb_valid=0, cdb_data all-zero, priority pointer ptr=0. cdb_ack is combinational, but it is forced to 0 while rst=1.
- Grant selection (combinational, each cycle):
  - Scan FU indices ptr, ptr+1, ..., ptr+NUM_FUS-1, taken mod NUM_FUS.
  - Select the first min(NUM_CDB, popcount(fu_done)) indices with fu_done=1.
  - The j-th selected FU in scan order maps to lane j.
  - cdb_ack[i]=1 exactly when FU i is selected.
  - An ack is never asserted for an FU whose fu_done=0.
- FU contract: an FU keeps fu_done and fu_data stable until the cycle in which cdb_ack is high. It may deassert fu_done, or present a new result, in the next cycle.
- Broadcast (registered, latency 1):
  - On the clock edge after a grant, cdb_valid[j]=1 and cdb_data[j] equals the granted FU's fu_data, copied verbatim.
  - Lanes with no grant: cdb_valid=0, and cdb_data holds its previous value.
- Pointer update:
  - If at least one grant occurred, ptr becomes (index of last granted FU + 1) mod NUM_FUS.
  - If there were no grants, ptr is unchanged.
- Fairness bound: a continuously requesting FU is granted within ceil(NUM_FUS/NUM_CDB) cycles.
- branch_mispredict=1:
  - That cycle, all cdb_ack=0, because the FUs self-flush.
  - On the next edge, all cdb_valid=0 and ptr is unchanged.
  - Any broadcast already registered before the mispredict cycle is shown normally in that cycle. ROB-side squash handles it.
- Requests present during the mispredict cycle are not granted. Acks resume in the following cycle based on the post-flush fu_done.
- Simultaneous full load (all fu_done=1): exactly NUM_CDB acks per cycle, rotating.
- Wrap-around: a scan that passes index NUM_FUS-1 continues at 0 within the same cycle.
- Reset mid-operation: outputs clear immediately. No partial broadcast appears after rst deasserts.
- No internal buffering beyond the output register: throughput is at most NUM_CDB results per cycle, with no skid.

Test Plan:
- Reset with fu_done=4'b1111 held: cdb_ack=0 during rst. After rst falls, cycle 0 acks FU0 and FU1 (ack=4'b0011). Next cycle cdb_valid=2'b11, cdb_data[0]=fu_data[0], cdb_data[1]=fu_data[1], and ptr=2.
- Saturation with all four FUs holding done:
  - Acks alternate 4'b0011, 4'b1100, 4'b0011, ...
  - Each FU is broadcast every 2 cycles.
- Single requester fu_done=4'b0100 with ptr=3:
  - The scan wraps: ack=4'b0100.
  - Lane 0 carries FU2 next cycle, lane 1 is invalid, and ptr becomes 3.
- Wrap with ptr=3 and fu_done=4'b1001:
  - Lane 0 carries FU3, lane 1 carries FU0.
  - ack=4'b1001 and ptr becomes 1.
- branch_mispredict pulse while fu_done=4'b0110:
  - ack=0 that cycle; the next cycle cdb_valid=0 and ptr is unchanged.
  - A lane that was valid during the mispredict cycle remains visible for that cycle only.
- Async reset asserted mid-broadcast (cdb_valid=2'b11): cdb_valid drops to 0 before the next clock edge, and ptr=0 after release.
